// File: rtl/calc_fsm_core.sv
// calc_fsm_core: button-driven calculator engine (capture A/B, pick opcode,
// run add/sub/shift-add multiply/restoring divide, present result until ack).
// Optional feature macro: CALC_ACCUM_EN -- ack in QDone chains the result
// into A and resumes at QGet_B instead of returning to QI.
module calc_fsm_core #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned CNT_W = 5
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic [WIDTH-1:0] In,
    input  logic             ButU,
    input  logic             ButD,
    input  logic             ButL,
    input  logic             ButR,
    output logic [WIDTH-1:0] C,
    output logic [WIDTH-1:0] Rem,
    output logic             Flag,
    output logic             Done,
    output logic             QI,
    output logic             QGet_A,
    output logic             QGet_B,
    output logic             QGet_Op,
    output logic             QAdd,
    output logic             QSub,
    output logic             QMul,
    output logic             QDiv,
    output logic             QErr,
    output logic             QDone
);

    localparam int unsigned PW = 2 * WIDTH;

    // One-hot state encoding; each bit drives one LED indicator directly.
    localparam logic [9:0] S_I      = 10'b00_0000_0001;
    localparam logic [9:0] S_GET_A  = 10'b00_0000_0010;
    localparam logic [9:0] S_GET_B  = 10'b00_0000_0100;
    localparam logic [9:0] S_GET_OP = 10'b00_0000_1000;
    localparam logic [9:0] S_ADD    = 10'b00_0001_0000;
    localparam logic [9:0] S_SUB    = 10'b00_0010_0000;
    localparam logic [9:0] S_MUL    = 10'b00_0100_0000;
    localparam logic [9:0] S_DIV    = 10'b00_1000_0000;
    localparam logic [9:0] S_ERR    = 10'b01_0000_0000;
    localparam logic [9:0] S_DONE   = 10'b10_0000_0000;

    localparam logic [CNT_W-1:0] MUL_LAST = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(WIDTH);

    logic [9:0]       state, state_n;
    logic [WIDTH-1:0] a_q, a_n, b_q, b_n;
    logic [WIDTH-1:0] c_n, rem_n;
    logic             flag_n, done_n;
    logic [CNT_W-1:0] cnt_q, cnt_n;
    // prod_q: multiply accumulator, or {partial remainder, dividend/quotient} when dividing
    logic [PW-1:0]    prod_q, prod_n;
    logic [PW-1:0]    mcand_q, mcand_n;
    logic [WIDTH-1:0] mplier_q, mplier_n;

    logic [WIDTH:0]   sum_w;
    logic [PW-1:0]    mul_acc;
    logic [WIDTH:0]   div_shift;
    logic             div_ge;
    logic [WIDTH-1:0] div_sub;
    logic [WIDTH-1:0] div_upper;
    logic [WIDTH-1:0] div_lower;

    // Arithmetic helpers for the single-step datapath
    assign sum_w     = {1'b0, a_q} + {1'b0, b_q};
    assign mul_acc   = mplier_q[0] ? (prod_q + mcand_q) : prod_q;
    assign div_shift = prod_q[PW-1:WIDTH-1];
    assign div_ge    = (div_shift >= {1'b0, b_q});
    assign div_sub   = WIDTH'(div_shift - {1'b0, b_q});
    assign div_upper = div_ge ? div_sub : div_shift[WIDTH-1:0];
    assign div_lower = {prod_q[WIDTH-2:0], div_ge};

    assign QI      = state[0];
    assign QGet_A  = state[1];
    assign QGet_B  = state[2];
    assign QGet_Op = state[3];
    assign QAdd    = state[4];
    assign QSub    = state[5];
    assign QMul    = state[6];
    assign QDiv    = state[7];
    assign QErr    = state[8];
    assign QDone   = state[9];

    // Registers: state, operands, iteration state and all visible outputs
    always_ff @(posedge Clk) begin
        if (!Reset) begin
            state    <= S_I;
            a_q      <= '0;
            b_q      <= '0;
            cnt_q    <= '0;
            prod_q   <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            C        <= '0;
            Rem      <= '0;
            Flag     <= 1'b0;
            Done     <= 1'b0;
        end else begin
            state    <= state_n;
            a_q      <= a_n;
            b_q      <= b_n;
            cnt_q    <= cnt_n;
            prod_q   <= prod_n;
            mcand_q  <= mcand_n;
            mplier_q <= mplier_n;
            C        <= c_n;
            Rem      <= rem_n;
            Flag     <= flag_n;
            Done     <= done_n;
        end
    end

    // Next-state and datapath update
    always_comb begin
        state_n  = state;
        a_n      = a_q;
        b_n      = b_q;
        cnt_n    = cnt_q;
        prod_n   = prod_q;
        mcand_n  = mcand_q;
        mplier_n = mplier_q;
        c_n      = C;
        rem_n    = Rem;
        flag_n   = Flag;
        done_n   = Done;

        unique case (state)
            S_I: begin
                if (ButL) state_n = S_GET_A;
            end
            S_GET_A: begin
                if (ButR) begin
                    a_n     = In;
                    state_n = S_GET_B;
                end
            end
            S_GET_B: begin
                if (ButR) begin
                    b_n     = In;
                    state_n = S_GET_OP;
                end
            end
            S_GET_OP: begin
                if (ButU || ButD || ButL || ButR) begin
                    c_n    = '0;
                    rem_n  = '0;
                    flag_n = 1'b0;
                    cnt_n  = '0;
                    if (ButU) begin
                        state_n = S_ADD;
                    end else if (ButD) begin
                        state_n = S_SUB;
                    end else if (ButL) begin
                        state_n  = S_MUL;
                        prod_n   = '0;
                        mcand_n  = {{WIDTH{1'b0}}, a_q};
                        mplier_n = b_q;
                    end else begin
                        state_n = S_DIV;
                        prod_n  = {{WIDTH{1'b0}}, a_q};
                    end
                end
            end
            S_ADD: begin
                c_n     = sum_w[WIDTH-1:0];
                flag_n  = sum_w[WIDTH];
                state_n = S_DONE;
                done_n  = 1'b1;
            end
            S_SUB: begin
                c_n     = a_q - b_q;
                flag_n  = (a_q < b_q);
                state_n = S_DONE;
                done_n  = 1'b1;
            end
            S_MUL: begin
                prod_n   = mul_acc;
                mcand_n  = mcand_q << 1;
                mplier_n = mplier_q >> 1;
                cnt_n    = cnt_q + CNT_W'(1);
                if (cnt_q == MUL_LAST) begin
                    c_n     = mul_acc[WIDTH-1:0];
                    flag_n  = |mul_acc[PW-1:WIDTH];
                    state_n = S_DONE;
                    done_n  = 1'b1;
                end
            end
            S_DIV: begin
                if (cnt_q == '0) begin
                    // Entry cycle: divisor check only
                    if (b_q == '0) begin
                        c_n     = {WIDTH{1'b1}};
                        rem_n   = a_q;
                        flag_n  = 1'b1;
                        state_n = S_ERR;
                        done_n  = 1'b1;
                    end else begin
                        cnt_n = CNT_W'(1);
                    end
                end else begin
                    prod_n = {div_upper, div_lower};
                    cnt_n  = cnt_q + CNT_W'(1);
                    if (cnt_q == DIV_LAST) begin
                        c_n     = div_lower;
                        rem_n   = div_upper;
                        flag_n  = (div_upper != '0);
                        state_n = S_DONE;
                        done_n  = 1'b1;
                    end
                end
            end
            S_DONE: begin
                if (ButL) begin
                    done_n = 1'b0;
`ifdef CALC_ACCUM_EN
                    a_n     = C;
                    state_n = S_GET_B;
`else
                    state_n = S_I;
`endif
                end
            end
            S_ERR: begin
                if (ButL) begin
                    done_n  = 1'b0;
                    state_n = S_I;
                end
            end
            default: begin
                state_n = S_I;
                done_n  = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_calc_fsm_core.sv
// Scoreboard bench for calc_fsm_core: stimulus pushes model results, a
// monitor pops and compares on each rising Done.
module tb_calc_fsm_core;

    localparam int unsigned W  = 16;
    localparam int unsigned PW = 2 * W;

`ifdef CALC_ACCUM_EN
    localparam bit ACCUM = 1'b1;
`else
    localparam bit ACCUM = 1'b0;
`endif

    // Expected state vectors, ordered {QI,QGet_A,QGet_B,QGet_Op,QAdd,QSub,QMul,QDiv,QErr,QDone}
    localparam logic [9:0] E_I    = 10'h200;
    localparam logic [9:0] E_GA   = 10'h100;
    localparam logic [9:0] E_GB   = 10'h080;
    localparam logic [9:0] E_GO   = 10'h040;
    localparam logic [9:0] E_ERR  = 10'h002;
    localparam logic [9:0] E_DONE = 10'h001;

    logic         Clk = 1'b0;
    logic         Reset = 1'b0;
    logic [W-1:0] In = '0;
    logic         ButU = 1'b0, ButD = 1'b0, ButL = 1'b0, ButR = 1'b0;
    logic [W-1:0] C, Rem;
    logic         Flag, Done;
    logic         QI, QGet_A, QGet_B, QGet_Op, QAdd, QSub, QMul, QDiv, QErr, QDone;

    calc_fsm_core #(.WIDTH(W), .CNT_W(5)) dut (
        .Clk(Clk), .Reset(Reset), .In(In),
        .ButU(ButU), .ButD(ButD), .ButL(ButL), .ButR(ButR),
        .C(C), .Rem(Rem), .Flag(Flag), .Done(Done),
        .QI(QI), .QGet_A(QGet_A), .QGet_B(QGet_B), .QGet_Op(QGet_Op),
        .QAdd(QAdd), .QSub(QSub), .QMul(QMul), .QDiv(QDiv),
        .QErr(QErr), .QDone(QDone)
    );

    always #5 Clk = ~Clk;

    typedef struct packed {
        logic [W-1:0] c;
        logic [W-1:0] rem;
        logic         flag;
        logic         err;
        logic [31:0]  lat;
        logic [31:0]  issue;
    } exp_t;

    exp_t         sb[$];
    int           checks = 0;
    int           failures = 0;
    int           cyc = 0;
    bit           at_getb = 1'b0;
    logic [W-1:0] acc_a = '0;
    logic         prev_done = 1'b0;

    always @(posedge Clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic logic [9:0] st_vec();
        return {QI, QGet_A, QGet_B, QGet_Op, QAdd, QSub, QMul, QDiv, QErr, QDone};
    endfunction

    // Reference: plain arithmetic on the operands, opcode priority U > D > L > R
    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                   input logic [3:0] m);
        exp_t        e;
        logic [W:0]  s;
        logic [PW-1:0] p;
        e = '0;
        if (m[3]) begin
            s = {1'b0, a} + {1'b0, b};
            e.c = s[W-1:0]; e.flag = s[W]; e.lat = 32'd2;
        end else if (m[2]) begin
            e.c = a - b; e.flag = (a < b); e.lat = 32'd2;
        end else if (m[1]) begin
            p = PW'(a) * PW'(b);
            e.c = p[W-1:0]; e.flag = (p[PW-1:W] != '0); e.lat = 32'(W + 1);
        end else if (b == '0) begin
            e.c = '1; e.rem = a; e.flag = 1'b1; e.err = 1'b1; e.lat = 32'd2;
        end else begin
            e.c = a / b; e.rem = a % b; e.flag = (e.rem != '0); e.lat = 32'(W + 2);
        end
        return e;
    endfunction

    // Monitor: structural checks every cycle, scoreboard pop on each rising Done
    always @(negedge Clk) begin
        exp_t e;
        if (Reset) begin
            chk("onehot", 64'($onehot(st_vec())), 64'd1);
            chk("done_vs_state", 64'(Done), 64'(QDone | QErr));
        end
        if (Done && !prev_done) begin
            chk("sb_nonempty", 64'(sb.size() != 0), 64'd1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk("C", 64'(C), 64'(e.c));
                chk("Rem", 64'(Rem), 64'(e.rem));
                chk("Flag", 64'(Flag), 64'(e.flag));
                chk("QErr", 64'(QErr), 64'(e.err));
                chk("latency", 64'(cyc - int'(e.issue) + 1), 64'(e.lat));
            end
        end
        prev_done = Done;
    end

    task automatic pulse(input logic [3:0] m);
        {ButU, ButD, ButL, ButR} = m;
        @(posedge Clk); #1;
        {ButU, ButD, ButL, ButR} = 4'b0;
    endtask

    task automatic do_reset();
        Reset = 1'b0;
        @(posedge Clk); #1;
        Reset = 1'b1;
        at_getb = 1'b0;
    endtask

    task automatic go_idle();
        if (at_getb) do_reset();
    endtask

    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic [3:0] m,
                          input bit noise, input bit finish);
        exp_t         e;
        int           n;
        logic [W-1:0] am;
        logic [3:0]   m2;
        if (!at_getb) begin
            chk("st_idle", 64'(st_vec()), 64'(E_I));
            In = W'($urandom);
            pulse(4'b0010);
            chk("st_get_a", 64'(st_vec()), 64'(E_GA));
            In = a;
            pulse(4'b0001);
            am = a;
        end else begin
            am = acc_a;
        end
        In = W'($urandom);
        chk("st_get_b", 64'(st_vec()), 64'(E_GB));
        In = b;
        pulse(4'b0001);
        In = W'($urandom);
        chk("st_get_op", 64'(st_vec()), 64'(E_GO));
        e = model(am, b, m);
        pulse(m);
        e.issue = 32'(cyc);
        if (!finish) return;
        sb.push_back(e);
        n = 0;
        while (!Done && n < 200) begin
            if (noise) {ButU, ButD, ButL, ButR} = 4'($urandom);
            In = W'($urandom);
            @(posedge Clk); #1;
            {ButU, ButD, ButL, ButR} = 4'b0;
            n++;
        end
        if (!Done) begin
            chk("done_timeout", 64'(n), 64'd0);
            do_reset();
            sb.delete();
            return;
        end
        m2 = 4'($urandom) & 4'b1101;
        pulse(m2);
        chk("hold_C", 64'(C), 64'(e.c));
        chk("hold_Rem", 64'(Rem), 64'(e.rem));
        chk("hold_Flag", 64'(Flag), 64'(e.flag));
        chk("hold_Done", 64'(Done), 64'd1);
        chk("hold_state", 64'(st_vec()), 64'(e.err ? E_ERR : E_DONE));
        pulse(4'b0010);
        chk("ack_state", 64'(st_vec()), 64'((!e.err && ACCUM) ? E_GB : E_I));
        chk("ack_Done", 64'(Done), 64'd0);
        at_getb = !e.err && ACCUM;
        acc_a   = e.c;
    endtask

    initial begin
        Reset = 1'b0;
        repeat (2) @(posedge Clk);
        #1;
        chk("rst_state", 64'(st_vec()), 64'(E_I));
        chk("rst_C", 64'(C), 64'd0);
        chk("rst_Rem", 64'(Rem), 64'd0);
        chk("rst_Flag", 64'(Flag), 64'd0);
        chk("rst_Done", 64'(Done), 64'd0);
        Reset = 1'b1;
        @(posedge Clk); #1;

        go_idle(); run_op(16'hFFFF, 16'h0002, 4'b1000, 1'b0, 1'b1);
        go_idle(); run_op(16'd3,    16'd5,    4'b0100, 1'b0, 1'b1);
        go_idle(); run_op(16'd5,    16'd3,    4'b0100, 1'b0, 1'b1);
        go_idle(); run_op(16'h0100, 16'h0300, 4'b0010, 1'b1, 1'b1);
        go_idle(); run_op(16'd25,   16'd4,    4'b0010, 1'b0, 1'b1);
        go_idle(); run_op(16'd100,  16'd7,    4'b0001, 1'b1, 1'b1);
        go_idle(); run_op(16'd9,    16'd0,    4'b0001, 1'b0, 1'b1);
        go_idle(); run_op(16'd7,    16'd9,    4'b1001, 1'b0, 1'b1);
        go_idle(); run_op(16'hFFFF, 16'hFFFF, 4'b0010, 1'b0, 1'b1);
        go_idle(); run_op(16'hFFFF, 16'h0001, 4'b0001, 1'b0, 1'b1);
`ifdef CALC_ACCUM_EN
        go_idle(); run_op(16'd2, 16'd3, 4'b1000, 1'b0, 1'b1);
        run_op(16'd0, 16'd4, 4'b1000, 1'b0, 1'b1);
`endif

        // Abort a division partway through with reset
        go_idle();
        run_op(16'd500, 16'd3, 4'b0001, 1'b0, 1'b0);
        repeat (4) @(posedge Clk);
        #1;
        Reset = 1'b0;
        @(posedge Clk); #1;
        Reset = 1'b1;
        at_getb = 1'b0;
        chk("abort_state", 64'(st_vec()), 64'(E_I));
        chk("abort_C", 64'(C), 64'd0);
        chk("abort_Rem", 64'(Rem), 64'd0);
        chk("abort_Flag", 64'(Flag), 64'd0);
        chk("abort_Done", 64'(Done), 64'd0);

        for (int i = 0; i < 30; i++) begin
            logic [W-1:0] ra, rb;
            ra = ($urandom_range(0, 3) == 0) ? W'($urandom_range(0, 20)) : W'($urandom);
            rb = ($urandom_range(0, 7) == 0) ? '0 :
                 (($urandom_range(0, 2) == 0) ? W'($urandom_range(1, 15)) : W'($urandom));
            run_op(ra, rb, 4'($urandom_range(1, 15)), 1'($urandom), 1'b1);
        end

        repeat (5) @(posedge Clk);
        #1;
        chk("sb_drained", 64'(sb.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
